// File: rtl/fru_config_sequencer_if.sv
// fru_config_sequencer_if: shadow-write, reconfig control and config-bus signals of the sequencer
interface fru_config_sequencer_if #(parameter int AW = 4);
  logic          cfg_we;
  logic [AW-1:0] cfg_waddr;
  logic [7:0]    cfg_wdata;
  logic          reconfig_req;
  logic          valid_in;
  logic          upstream_stall;
  logic          tracing;
  logic [7:0]    configId;
  logic [7:0]    configData;
  logic          busy;
  logic          reconfig_done;
  logic          cfg_dropped;
  modport master (
    output cfg_we, cfg_waddr, cfg_wdata, reconfig_req, valid_in,
    input  upstream_stall, tracing, configId, configData, busy, reconfig_done, cfg_dropped
  );
  modport slave (
    input  cfg_we, cfg_waddr, cfg_wdata, reconfig_req, valid_in,
    output upstream_stall, tracing, configId, configData, busy, reconfig_done, cfg_dropped
  );
endinterface

// File: rtl/fru_config_sequencer.sv
// fru_config_sequencer: drains the pipeline, then streams the shadow firmware table to a filter-reduce unit
module fru_config_sequencer #(
  parameter int         MAX_CHAINS       = 4,
  parameter logic [7:0] TARGET_CONFIG_ID = 8'h00,
  parameter logic [7:0] IDLE_CONFIG_ID   = 8'hFF,
  parameter int         DRAIN_CYCLES     = 2
) (
  input logic clk,
  input logic rst,
  fru_config_sequencer_if.slave bus
);
  localparam int NBYTES = 3 * MAX_CHAINS;
  localparam int AW = $clog2(NBYTES);
  localparam int CW = $clog2(DRAIN_CYCLES + 1);
  localparam logic [AW-1:0] LAST = AW'(NBYTES - 1);
  typedef enum logic [2:0] {IDLE, DRAIN, PREP, STREAM, RESUME} state_t;
  state_t        state_q;
  logic [CW-1:0] cnt_q;
  logic [AW-1:0] idx_q;
  logic [7:0]    shadow_q [NBYTES];
  logic          tracing_q, stall_q, busy_q, done_q, dropped_q;
  logic [7:0]    id_q, data_q;
  logic          wr_ok;
  assign wr_ok = bus.cfg_we && state_q == IDLE && bus.cfg_waddr <= LAST;
  assign bus.tracing        = tracing_q;
  assign bus.upstream_stall = stall_q;
  assign bus.configId       = id_q;
  assign bus.configData     = data_q;
  assign bus.busy           = busy_q;
  assign bus.reconfig_done  = done_q;
  assign bus.cfg_dropped    = dropped_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NBYTES; i++) shadow_q[i] <= '0;
      dropped_q <= 1'b0;
    end else begin
      dropped_q <= bus.cfg_we && !wr_ok;
      if (wr_ok) shadow_q[bus.cfg_waddr] <= bus.cfg_wdata;
    end
  end
  // Outputs are loaded on the transition into each state so they appear with it.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      idx_q     <= '0;
      tracing_q <= 1'b1;
      stall_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      id_q      <= IDLE_CONFIG_ID;
      data_q    <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: if (bus.reconfig_req) begin
          state_q <= DRAIN;
          cnt_q   <= '0;
          stall_q <= 1'b1;
          busy_q  <= 1'b1;
        end
        DRAIN: if (bus.valid_in) cnt_q <= '0;
        else if (cnt_q == CW'(DRAIN_CYCLES - 1)) begin
          state_q   <= PREP;
          tracing_q <= 1'b0;
        end else cnt_q <= cnt_q + 1'b1;
        PREP: begin
          state_q <= STREAM;
          idx_q   <= '0;
          id_q    <= TARGET_CONFIG_ID;
          data_q  <= shadow_q[0];
        end
        STREAM: if (idx_q == LAST) begin
          state_q <= RESUME;
          id_q    <= IDLE_CONFIG_ID;
          data_q  <= '0;
        end else begin
          idx_q  <= idx_q + 1'b1;
          data_q <= shadow_q[idx_q + 1'b1];
        end
        RESUME: begin
          state_q   <= IDLE;
          tracing_q <= 1'b1;
          stall_q   <= 1'b0;
          busy_q    <= 1'b0;
          done_q    <= 1'b1;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule
